// File: rtl/param_alu_seq.sv
// param_alu_seq: registered WIDTH-bit ALU with a Start/Busy/Done handshake.
// Eight opcodes (ADD, SUB, AND, XOR, OR, SHL, SHR, MUL) with Cout/OVR/Z/N flags.
// Optional feature macro: PARAM_ALU_MUL_EN.
//   Defined:   opcode 111 runs an iterative shift-add unsigned multiplier
//              (WIDTH edges, 2*WIDTH-bit product on {Rhi,R}).
//   Undefined: opcode 111 completes in one edge as an illegal opcode
//              (R=0, Rhi=0, OVR=1, Z=1).
//
// state | meaning
// IDLE  | waiting for Start; operands are latched on the accepting edge
// EXEC  | single-edge operation; writes results and flags, pulses Done
// MUL   | shift-add iterations under a down-counter (PARAM_ALU_MUL_EN only)
module param_alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Rhi,
  output logic             Cout,
  output logic             OVR,
  output logic             Z,
  output logic             N,
  output logic             Busy,
  output logic             Done
);

`ifdef PARAM_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_s;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] ex_r;
  logic             ex_c, ex_v;

  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef PARAM_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0]     psum;
  logic [CW-1:0]      cnt;

  // One shift-add step: conditionally add the multiplicand to the upper half,
  // then shift the whole accumulator (including the add carry) right by one.
  always_comb begin
    psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : {(WIDTH+1){1'b0}});
    acc_nxt = {psum, acc[WIDTH-1:1]};
  end
`endif

  // Single-edge opcode results and flags, computed from the latched operands.
  always_comb begin
    ex_r = '0;
    ex_c = 1'b0;
    ex_v = 1'b0;
    case (op_s)
      3'b000: begin
        ex_r = add_w[WIDTH-1:0];
        ex_c = add_w[WIDTH];
        ex_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'b001: begin
        ex_r = sub_w[WIDTH-1:0];
        ex_c = sub_w[WIDTH];
        ex_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'b010: ex_r = op_a & op_b;
      3'b011: ex_r = op_a ^ op_b;
      3'b100: ex_r = op_a | op_b;
      3'b101: begin
        ex_r = {op_a[WIDTH-2:0], 1'b0};
        ex_c = op_a[WIDTH-1];
        ex_v = op_a[WIDTH-1] ^ op_a[WIDTH-2];
      end
      3'b110: begin
        ex_r = {1'b0, op_a[WIDTH-1:1]};
        ex_c = op_a[0];
      end
      default: begin
        // Only reachable without the multiplier: flag the opcode as illegal.
        ex_v = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef PARAM_ALU_MUL_EN
          state_nxt = (S == 3'b111) ? MUL : EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
      EXEC: state_nxt = IDLE;
`ifdef PARAM_ALU_MUL_EN
      MUL: if (cnt == '0) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  // Operand capture, multiplier iteration and registered results/flags.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      op_a <= '0;
      op_b <= '0;
      op_s <= '0;
      R    <= '0;
      Rhi  <= '0;
      Cout <= 1'b0;
      OVR  <= 1'b0;
      Z    <= 1'b0;
      N    <= 1'b0;
      Done <= 1'b0;
`ifdef PARAM_ALU_MUL_EN
      acc  <= '0;
      cnt  <= '0;
`endif
    end else begin
      Done <= 1'b0;
      if (state == IDLE && Start) begin
        op_a <= A;
        op_b <= B;
        op_s <= S;
`ifdef PARAM_ALU_MUL_EN
        acc  <= {{WIDTH{1'b0}}, B};
        cnt  <= CW'(WIDTH - 1);
`endif
      end
      if (state == EXEC) begin
        R    <= ex_r;
        Rhi  <= '0;
        Cout <= ex_c;
        OVR  <= ex_v;
        Z    <= ~|ex_r;
        N    <= ex_r[WIDTH-1];
        Done <= 1'b1;
      end
`ifdef PARAM_ALU_MUL_EN
      if (state == MUL) begin
        acc <= acc_nxt;
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          R    <= acc_nxt[WIDTH-1:0];
          Rhi  <= acc_nxt[2*WIDTH-1:WIDTH];
          Cout <= |acc_nxt[2*WIDTH-1:WIDTH];
          OVR  <= |acc_nxt[2*WIDTH-1:WIDTH];
          Z    <= ~|acc_nxt;
          N    <= acc_nxt[WIDTH-1];
          Done <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_param_alu_seq.sv
// Scoreboarded bench for param_alu_seq at WIDTH=4 and WIDTH=8.
// Expected results (with their completion cycle) are queued at issue time;
// monitors pop and compare on every Done pulse.
module tb_param_alu_seq;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Resetn;

  logic       Start4, c4, v4, z4, n4, busy4, done4;
  logic [2:0] S4;
  logic [3:0] A4, B4, r4, rhi4;

  logic       Start8, c8, v8, z8, n8, busy8, done8;
  logic [2:0] S8;
  logic [7:0] A8, B8, r8, rhi8;

  param_alu_seq #(.WIDTH(4)) dut4 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start4), .S(S4), .A(A4), .B(B4),
    .R(r4), .Rhi(rhi4), .Cout(c4), .OVR(v4), .Z(z4), .N(n4), .Busy(busy4), .Done(done4)
  );

  param_alu_seq #(.WIDTH(8)) dut8 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start8), .S(S8), .A(A8), .B(B8),
    .R(r8), .Rhi(rhi8), .Cout(c8), .OVR(v8), .Z(z8), .N(n8), .Busy(busy8), .Done(done8)
  );

  typedef struct {
    string       name;
    logic [31:0] r;
    logic [31:0] rhi;
    logic [3:0]  f;    // {Cout, OVR, Z, N}
    int          cyc;
  } exp_t;

  exp_t q4[$], q8[$];
  exp_t e4, e8;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  logic prev_done4 = 1'b0, prev_done8 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Monitor: count cycles, compare each completion against the scoreboard.
  always begin
    @(posedge Clock);
    cyc++;
    #1;
    if (done4) begin
      chk("done4_width", {63'b0, prev_done4}, 64'd0);
      if (q4.size() == 0) chk("done4_unexpected", {63'b0, done4}, 64'd0);
      else begin
        e4 = q4.pop_front();
        chk(e4.name, {16'(cyc), 16'(r4), 16'(rhi4), 12'({c4, v4, z4, n4})},
                     {16'(e4.cyc), 16'(e4.r), 16'(e4.rhi), 12'(e4.f)});
      end
    end
    if (done8) begin
      chk("done8_width", {63'b0, prev_done8}, 64'd0);
      if (q8.size() == 0) chk("done8_unexpected", {63'b0, done8}, 64'd0);
      else begin
        e8 = q8.pop_front();
        chk(e8.name, {16'(cyc), 16'(r8), 16'(rhi8), 12'({c8, v8, z8, n8})},
                     {16'(e8.cyc), 16'(e8.r), 16'(e8.rhi), 12'(e8.f)});
      end
    end
    prev_done4 = done4;
    prev_done8 = done8;
  end

  // Pulse Start for one edge, then scramble the operands to prove they were latched.
  task automatic issue4(input string nm, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                        input bit push, input logic [3:0] er, input logic [3:0] erhi,
                        input logic [3:0] ef, input int lat);
    @(negedge Clock);
    S4 = s; A4 = a; B4 = b; Start4 = 1'b1;
    @(posedge Clock);
    #1;
    Start4 = 1'b0;
    if (push) q4.push_back('{nm, 32'(er), 32'(erhi), ef, cyc + lat});
    A4 = ~a; B4 = ~b; S4 = ~s;
  endtask

  task automatic issue8(input string nm, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [7:0] erhi,
                        input logic [3:0] ef, input int lat);
    @(negedge Clock);
    S8 = s; A8 = a; B8 = b; Start8 = 1'b1;
    @(posedge Clock);
    #1;
    Start8 = 1'b0;
    q8.push_back('{nm, 32'(er), 32'(erhi), ef, cyc + lat});
    A8 = ~a; B8 = ~b; S8 = ~s;
  endtask

  task automatic wait_idle4();
    for (int i = 0; i < 40 && busy4; i++) begin
      @(posedge Clock);
      #1;
    end
    chk("busy4_falls", {63'b0, busy4}, 64'd0);
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 40 && busy8; i++) begin
      @(posedge Clock);
      #1;
    end
    chk("busy8_falls", {63'b0, busy8}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    Resetn = 1'b0;
    Start4 = 1'b0; S4 = '0; A4 = '0; B4 = '0;
    Start8 = 1'b0; S8 = '0; A8 = '0; B8 = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset4_outputs", 64'({r4, rhi4, c4, v4, z4, n4, busy4, done4}), 64'd0);
    chk("reset8_outputs", 64'({r8, rhi8, c8, v8, z8, n8, busy8, done8}), 64'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    issue4("add_ovf",    3'b000, 4'b0111, 4'b0001, 1, 4'b1000, 4'b0000, 4'b0101, 1); wait_idle4();
    issue4("sub_borrow", 3'b001, 4'b0011, 4'b0101, 1, 4'b1110, 4'b0000, 4'b0001, 1); wait_idle4();
    issue4("sub_zero",   3'b001, 4'b0101, 4'b0101, 1, 4'b0000, 4'b0000, 4'b1010, 1); wait_idle4();
    issue4("and",        3'b010, 4'b1100, 4'b1010, 1, 4'b1000, 4'b0000, 4'b0001, 1); wait_idle4();
    issue4("xor",        3'b011, 4'b1100, 4'b1010, 1, 4'b0110, 4'b0000, 4'b0000, 1); wait_idle4();
    issue4("or",         3'b100, 4'b0001, 4'b0100, 1, 4'b0101, 4'b0000, 4'b0000, 1); wait_idle4();

`ifdef PARAM_ALU_MUL_EN
    issue4("mul_ff", 3'b111, 4'b1111, 4'b1111, 1, 4'b0001, 4'b1110, 4'b1100, 4);
    @(negedge Clock);
    chk("busy_mid_mul", {63'b0, busy4}, 64'd1);
    S4 = 3'b000; A4 = 4'b0001; B4 = 4'b0001; Start4 = 1'b1;
    @(posedge Clock);
    #1;
    Start4 = 1'b0;
    wait_idle4();
    issue4("mul_zero", 3'b111, 4'b0000, 4'b1011, 1, 4'b0000, 4'b0000, 4'b0010, 4); wait_idle4();
    issue4("mul_21",   3'b111, 4'b0111, 4'b0011, 1, 4'b0101, 4'b0001, 4'b1100, 4); wait_idle4();
`else
    issue4("illegal_op", 3'b111, 4'b0011, 4'b0011, 1, 4'b0000, 4'b0000, 4'b0110, 1); wait_idle4();
`endif

    // Back-to-back with Start held: SHL then SHR, Done pulses two cycles apart.
    @(negedge Clock);
    S4 = 3'b101; A4 = 4'b1001; B4 = 4'b0000; Start4 = 1'b1;
    @(posedge Clock);
    #1;
    k = cyc;
    q4.push_back('{"b2b_shl", 32'h2, 32'h0, 4'b1100, k + 1});
    S4 = 3'b110;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    chk("b2b_second_accepted", {63'b0, busy4}, 64'd1);
    q4.push_back('{"b2b_shr", 32'h4, 32'h0, 4'b1000, k + 3});
    Start4 = 1'b0;
    wait_idle4();

    // Reset during an operation in flight: outputs clear at once, no Done follows.
`ifdef PARAM_ALU_MUL_EN
    issue4("rst_mul", 3'b111, 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4);
    repeat (2) @(posedge Clock);
`else
    issue4("rst_add", 3'b000, 4'b0011, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 1);
`endif
    #2;
    Resetn = 1'b0;
    #1;
    chk("reset_mid_op", 64'({r4, rhi4, c4, v4, z4, n4, busy4, done4}), 64'd0);
    @(negedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (8) @(posedge Clock);
    #1;
    chk("post_reset_idle", 64'({busy4, done4, r4}), 64'd0);

    issue4("add_wrap", 3'b000, 4'b1111, 4'b0001, 1, 4'b0000, 4'b0000, 4'b1010, 1); wait_idle4();

    issue8("add8_ff",  3'b000, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1010, 1); wait_idle8();
    issue8("sub8_ovf", 3'b001, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b1100, 1); wait_idle8();
    issue8("shl8",     3'b101, 8'hC0, 8'h00, 8'h80, 8'h00, 4'b1001, 1); wait_idle8();
`ifdef PARAM_ALU_MUL_EN
    issue8("mul8_256", 3'b111, 8'h10, 8'h10, 8'h00, 8'h01, 4'b1100, 8); wait_idle8();
`endif

    repeat (3) @(posedge Clock);
    #1;
    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
